// File: rtl/digit_serial_mult_ctrl_pkg.sv
// Shared definitions for the digit-serial multiplier controller: digit width,
// FSM state encoding and the operand digit-count helper.
package digit_serial_mult_ctrl_pkg;

   localparam int DIGIT_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int digit_count(input int width);
      return width / DIGIT_W;
   endfunction

endpackage

// File: rtl/two_bit_multiplier.sv
// Combinational 2x2 unsigned multiplier; the shared arithmetic element that the
// digit-serial controller time-multiplexes over all digit pairs.
module two_bit_multiplier (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] p
);

   assign p = {2'b00, a} * {2'b00, b};

endmodule

// File: rtl/digit_serial_mult_ctrl.sv
// Digit-serial WIDTH x WIDTH unsigned multiplier: one 2x2 multiply per clock over
// every digit pair, accumulated with shifts, behind valid/ready handshakes.
module digit_serial_mult_ctrl
   import digit_serial_mult_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int D     = digit_count(WIDTH);
   localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
   localparam int PW    = 2 * WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D - 1);

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [IDX_W-1:0]     i_q, j_q;
   logic [PW-1:0]        acc_q;
   logic [DIGIT_W-1:0]   a_dig, b_dig;
   logic [2*DIGIT_W-1:0] pp;
   logic [PW-1:0]        pp_shifted;
   logic                 last_pair;
   logic                 accept;

   assign a_dig      = a_q[DIGIT_W*int'(i_q) +: DIGIT_W];
   assign b_dig      = b_q[DIGIT_W*int'(j_q) +: DIGIT_W];
   assign pp_shifted = PW'(pp) << (DIGIT_W * (int'(i_q) + int'(j_q)));
   assign last_pair  = (i_q == LAST_IDX) && (j_q == LAST_IDX);
   assign accept     = in_valid && in_ready;
   assign product    = acc_q;

   two_bit_multiplier u_mult (
      .a (a_dig),
      .b (b_dig),
      .p (pp)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path leaves
   // a signal unassigned and a latch cannot be inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last_pair) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: in_ready = 1'b1;
         RUN:  busy     = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: the operand copies and indices are cleared on reset as well, so a
   // reset mid-run leaves no stale digits and product reads zero afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         i_q   <= '0;
         j_q   <= '0;
         acc_q <= '0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b;
         i_q   <= '0;
         j_q   <= '0;
         acc_q <= '0;
      end else if (state == RUN) begin
         acc_q <= acc_q + pp_shifted;
         // j is the inner index; i advances when j wraps, and both wrap to 0
         // after the final pair so DONE sees a clean index state.
         if (j_q == LAST_IDX) begin
            j_q <= '0;
            i_q <= (i_q == LAST_IDX) ? '0 : i_q + 1'b1;
         end else begin
            j_q <= j_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_digit_serial_mult_ctrl.sv
// Self-checking bench for digit_serial_mult_ctrl at WIDTH=8 and WIDTH=4: directed
// scenarios plus a randomized sweep against a cycle-count/arithmetic model.
module tb_digit_serial_mult_ctrl;

   localparam int N_RAND    = 1000;
   localparam int RUN8      = 16;
   localparam int RUN4      = 4;
   localparam int RAND_LIMIT = 80000;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv8, ir8, ov8, or8, bz8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        iv4, ir4, ov4, or4, bz4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          res8 = 0;
   int          res4 = 0;
   int          m_wait8 = 0;
   int          m_wait4 = 0;
   int unsigned m_prod8 = 0;
   int unsigned m_prod4 = 0;
   int unsigned q8[$];
   int unsigned q4[$];
   bit          rnd_or = 1'b0;

   always #5 clk = ~clk;

   digit_serial_mult_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .out_valid(ov8), .out_ready(or8), .product(p8), .busy(bz8));

   digit_serial_mult_ctrl #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .out_valid(ov4), .out_ready(or4), .product(p4), .busy(bz4));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: 0 = idle, >0 = multiply cycles still to go, -1 = result on offer.
   function automatic int model_step(input int w, input int run_len, input logic in_v,
                                     input logic out_r);
      if (w == 0)  return in_v ? run_len : 0;
      if (w > 0)   return (w == 1) ? -1 : w - 1;
      return out_r ? 0 : -1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_wait8 = 0;
         m_wait4 = 0;
      end else begin
         if (m_wait8 == 0 && iv8) m_prod8 = 32'(a8) * 32'(b8);
         if (m_wait4 == 0 && iv4) m_prod4 = 32'(a4) * 32'(b4);
         m_wait8 = model_step(m_wait8, RUN8, iv8, or8);
         m_wait4 = model_step(m_wait4, RUN4, iv4, or4);
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         q8.delete();
         q4.delete();
      end else begin
         check("in_ready8",  64'(ir8), 64'(m_wait8 == 0));
         check("out_valid8", 64'(ov8), 64'(m_wait8 == -1));
         check("busy8",      64'(bz8), 64'(m_wait8 != 0));
         if (m_wait8 == -1) check("product8", 64'(p8), 64'(m_prod8));
         check("in_ready4",  64'(ir4), 64'(m_wait4 == 0));
         check("out_valid4", 64'(ov4), 64'(m_wait4 == -1));
         check("busy4",      64'(bz4), 64'(m_wait4 != 0));
         if (m_wait4 == -1) check("product4", 64'(p4), 64'(m_prod4));
         if (iv8 && ir8) q8.push_back(32'(a8) * 32'(b8));
         if (iv4 && ir4) q4.push_back(32'(a4) * 32'(b4));
         if (ov8 && or8) begin
            check("result8_expected", 64'(q8.size() > 0), 64'd1);
            if (q8.size() > 0) check("sb_product8", 64'(p8), 64'(q8.pop_front()));
            res8++;
         end
         if (ov4 && or4) begin
            check("result4_expected", 64'(q4.size() > 0), 64'd1);
            if (q4.size() > 0) check("sb_product4", 64'(p4), 64'(q4.pop_front()));
            res4++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_or) begin
         or8 = ($urandom % 4) != 0;
         or4 = ($urandom % 4) != 0;
      end
   endtask

   task automatic send8(input logic [7:0] av, input logic [7:0] bv);
      int n = 0;
      a8  = av;
      b8  = bv;
      iv8 = 1'b1;
      while (!ir8 && n < 200) begin
         step();
         n++;
      end
      check("accept8_bound", 64'(ir8), 64'd1);
      step();
      iv8 = 1'b0;
   endtask

   task automatic wait_ov8(output int n);
      n = 0;
      while (!ov8 && n < 200) begin
         step();
         n++;
      end
      if (!ov8) check("ov8_timeout", 64'(ov8), 64'd1);
   endtask

   function automatic logic [7:0] pick8();
      case ($urandom % 8)
         0:       return 8'h00;
         1:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      int n;
      int cyc;
      int sent8, sent4, base8, base4;
      bit acc8, acc4;

      rst = 1'b1;
      iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
      iv4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      check("reset_in_ready",  64'(ir8), 64'd1);
      check("reset_out_valid", 64'(ov8), 64'd0);
      check("reset_busy",      64'(bz8), 64'd0);
      check("reset_product8",  64'(p8),  64'd0);
      check("reset_product4",  64'(p4),  64'd0);

      // 3*5 with immediate consumption: 16-cycle latency, one-cycle pulse
      or8 = 1'b1;
      send8(8'd3, 8'd5);
      wait_ov8(n);
      check("lat_3x5", 64'(n), 64'd16);
      check("prod_3x5", 64'(p8), 64'd15);
      step();
      check("pulse_3x5", 64'(ov8), 64'd0);

      send8(8'd255, 8'd255);
      wait_ov8(n);
      check("prod_255x255", 64'(p8), 64'hFE01);
      step();
      send8(8'd0, 8'd200);
      wait_ov8(n);
      check("lat_0x200", 64'(n), 64'd16);
      check("prod_0x200", 64'(p8), 64'd0);
      step();

      // back-pressure: result held for 10 cycles
      or8 = 1'b0;
      send8(8'h5A, 8'h24);
      wait_ov8(n);
      for (int k = 0; k < 10; k++) begin
         step();
         check("bp_valid", 64'(ov8), 64'd1);
         check("bp_product", 64'(p8), 64'h0CA8);
         check("bp_in_ready", 64'(ir8), 64'd0);
      end
      or8 = 1'b1;
      step();
      check("bp_release", 64'(ov8), 64'd0);

      // new request raised mid-run, held through DONE, accepted only from IDLE
      send8(8'd2, 8'd3);
      repeat (3) step();
      a8 = 8'd7; b8 = 8'd9; iv8 = 1'b1;
      wait_ov8(n);
      check("lat_2x3", 64'(n + 3), 64'd16);
      check("prod_2x3", 64'(p8), 64'd6);
      step();
      check("idle_after_done", 64'(ir8), 64'd1);
      check("no_valid_after_done", 64'(ov8), 64'd0);
      step();
      iv8 = 1'b0;
      wait_ov8(n);
      check("lat_7x9", 64'(n), 64'd16);
      check("prod_7x9", 64'(p8), 64'd63);
      step();

      // reset mid-run discards the partial result
      send8(8'd100, 8'd100);
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_in_ready", 64'(ir8), 64'd1);
      check("rst_out_valid", 64'(ov8), 64'd0);
      check("rst_busy", 64'(bz8), 64'd0);
      check("rst_product", 64'(p8), 64'd0);
      send8(8'd12, 8'd12);
      wait_ov8(n);
      check("prod_12x12", 64'(p8), 64'd144);
      step();

      // randomized sweep on both widths with random consumer stalls
      rnd_or = 1'b1;
      sent8 = 0; sent4 = 0; cyc = 0;
      base8 = res8; base4 = res4;
      while ((sent8 < N_RAND || sent4 < N_RAND || q8.size() > 0 || q4.size() > 0 ||
              iv8 || iv4) && cyc < RAND_LIMIT) begin
         if (!iv8 && sent8 < N_RAND && ($urandom % 4) != 0) begin
            iv8 = 1'b1; a8 = pick8(); b8 = pick8();
         end
         if (!iv4 && sent4 < N_RAND && ($urandom % 4) != 0) begin
            iv4 = 1'b1; a4 = 4'(pick8()); b4 = 4'(pick8());
         end
         acc8 = iv8 && ir8;
         acc4 = iv4 && ir4;
         step();
         cyc++;
         if (acc8) begin iv8 = 1'b0; sent8++; end
         if (acc4) begin iv4 = 1'b0; sent4++; end
      end
      check("rand_in_budget", 64'(cyc < RAND_LIMIT), 64'd1);
      check("rand_results8", 64'(res8 - base8), 64'(N_RAND));
      check("rand_results4", 64'(res4 - base4), 64'(N_RAND));
      check("rand_pending8", 64'(q8.size()), 64'd0);
      check("rand_pending4", 64'(q4.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
